multdiv_iter: RTL and testbench
===============================

MULTDIV_ITER -- requirements
Module: multdiv_iter

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width (even, >= 4).
REQ-002 SHALL provide port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port ctrl_MULT  input  1  one-cycle start pulse for signed multiply.
REQ-005 SHALL provide port ctrl_DIV  input  1  one-cycle start pulse for signed divide.
REQ-006 SHALL provide port data_operandA  input  WIDTH  multiplicand / dividend, sampled on the start edge only.
REQ-007 SHALL provide port data_operandB  input  WIDTH  multiplier / divisor, sampled on the start edge only.
REQ-008 SHALL provide port data_result  output  WIDTH  low WIDTH bits of product, or quotient.
REQ-009 SHALL provide port data_exception  output  1  overflow or divide-by-zero flag, valid with data_resultRDY.
REQ-010 SHALL provide port data_resultRDY  output  1  one-cycle pulse: result and exception valid.
REQ-011 SHALL provide port busy  output  1  high while an operation is in flight; pipeline stall source.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, FIX, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-013 SHALL, on an edge with exactly one of ctrl_MULT/ctrl_DIV high, latch both operands and enter MUL or DIV, from any state.
REQ-014 SHALL, when a start arrives in a non-IDLE state, abort the current operation with no RDY pulse and restart with the new operands.
REQ-015 SHALL ignore an edge with ctrl_MULT and ctrl_DIV both high: no state change, no RDY.
REQ-016 SHALL multiply signed two's-complement by iterative shift-add over a 2*WIDTH product register, counter width clog2(WIDTH)+1.
REQ-017 SHALL flag multiply exception when the 2*WIDTH product is not the sign-extension of its low WIDTH bits.
REQ-018 SHALL divide by restoring division on magnitudes for WIDTH iterations, then spend one FIX cycle negating the quotient when operand signs differ.
REQ-019 SHALL truncate the quotient toward zero and discard the remainder.
REQ-020 SHALL, for divisor 0, skip iteration: data_result 0, data_exception 1, RDY on the edge after the start edge.
REQ-021 SHALL, for dividend -2^(WIDTH-1) divided by -1, return -2^(WIDTH-1) with data_exception 1 at normal latency.
REQ-022 SHALL have latency, counted from start edge T0, of RDY high after edge T0+N: N = WIDTH multiply (radix-2), N = WIDTH+1 divide.
REQ-023 SHALL assert busy from the edge after the start through the edge that raises RDY, and deassert it in the RDY cycle.
REQ-024 SHALL hold data_result and data_exception stable from RDY until the next start edge or reset.

Reset
REQ-025 SHALL, with reset high on an edge, enter IDLE and clear data_result, data_exception, data_resultRDY, busy and the counter to 0.
REQ-026 SHALL give reset priority over a simultaneous start; a reset mid-operation discards it with no RDY pulse.

Configuration
REQ-027 SHALL, when MULTDIV_BOOTH4_EN is defined, multiply by radix-4 modified Booth recoding, giving multiply N = WIDTH/2, with identical results and exception semantics.
REQ-028 SHALL, when MULTDIV_BOOTH4_EN is undefined, use radix-2 shift-add with N = WIDTH; divide is unaffected either way.

Verification
REQ-029 SHALL check, with WIDTH=32: MULT 7 x -3 -> data_result 0xFFFFFFEB, exception 0, RDY after edge T0+32 (T0+16 with MULTDIV_BOOTH4_EN).
REQ-030 SHALL check: MULT 0x00010000 x 0x00010000 -> data_result 0x00000000, exception 1.
REQ-031 SHALL check: DIV -7 / 2 -> 0xFFFFFFFD, exception 0, RDY after edge T0+33; DIV 5 / 0 -> 0, exception 1, RDY after T0+1.
REQ-032 SHALL check: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, exception 1.
REQ-033 SHALL check: reset at T0+10 of a MULT -> IDLE, all outputs 0, no RDY for 40 cycles; then MULT 3 x 4 -> 12.
REQ-034 SHALL check: ctrl_MULT and ctrl_DIV both high -> busy stays 0, no RDY; a DIV start at T0+5 of a MULT -> single RDY after T0+5+33, carrying the quotient.

Source files
------------

// File: rtl/multdiv_iter_if.sv
// -----------------------------------------------------------------------------
// multdiv_iter_if -- request/response bundle for the iterative multiply/divide
// unit.
//
// Handshake: a start is a one-cycle pulse on exactly one of ctrl_MULT /
// ctrl_DIV; the operands are sampled only on that edge. The unit answers with
// a one-cycle data_resultRDY pulse, and data_result / data_exception are valid
// in that cycle and held until the next start or reset. busy is high while an
// operation is in flight. There is no back-pressure: the unit always accepts a
// start, and a start during an operation aborts it.
//
// Signals:
//   ctrl_MULT, ctrl_DIV            start pulses              (master -> slave)
//   data_operandA, data_operandB   operands, WIDTH bits      (master -> slave)
//   data_result                    product low half/quotient (slave -> master)
//   data_exception                 overflow / divide-by-zero (slave -> master)
//   data_resultRDY                 one-cycle result strobe   (slave -> master)
//   busy                           operation in flight       (slave -> master)
// -----------------------------------------------------------------------------
interface multdiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_iter.sv
// -----------------------------------------------------------------------------
// multdiv_iter -- iterative signed multiplier / restoring divider.
//
// Multiply: signed shift-add over a 2*WIDTH product register, WIDTH cycles.
//   With MULTDIV_BOOTH4_EN defined, radix-4 modified Booth recoding is used
//   instead, WIDTH/2 cycles, identical results and exception flag.
// Divide: restoring division on magnitudes, WIDTH cycles, then one FIX cycle
//   that applies the quotient sign. Divisor 0 finishes one cycle after start.
//
// Ports:
//   clock        single clock, rising edge
//   reset        synchronous, active-high
//   bus          multdiv_iter_if.slave (start pulses, operands, result, busy)
//   dbg_state_o  current FSM state, for observation only
// -----------------------------------------------------------------------------
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  multdiv_iter_if.slave bus,
  output logic [2:0]    dbg_state_o
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

`ifdef MULTDIV_BOOTH4_EN
  localparam int MPW       = W + 1;  // multiplier plus the implicit 0 below bit 0
  localparam int MUL_STEPS = W / 2;
`else
  localparam int MPW       = W;
  localparam int MUL_STEPS = W;
`endif
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STEPS - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(W - 1);

  logic [2:0]     state_q,  state_d;
  logic [CW-1:0]  cnt_q,    cnt_d;
  logic [2*W-1:0] prod_q,   prod_d;
  logic [2*W-1:0] mcand_q,  mcand_d;
  logic [MPW-1:0] mplier_q, mplier_d;
  logic [W-1:0]   quo_q,    quo_d;
  logic [W-1:0]   rem_q,    rem_d;
  logic [W-1:0]   dvs_q,    dvs_d;
  logic           neg_q,    neg_d;     // quotient sign must be flipped
  logic           dz_q,     dz_d;      // divisor was zero
  logic           ovf_q,    ovf_d;     // most-negative / -1
  logic [W-1:0]   result_q, result_d;
  logic           exc_q,    exc_d;
  logic           rdy_q,    rdy_d;
  logic           busy_q,   busy_d;

  logic           start;
  logic [W-1:0]   a_mag, b_mag;
  logic [2*W-1:0] mul_term, mul_sum;
  logic           mul_ovf;
  logic [W:0]     div_shift;
  logic           div_ge;

  assign start = bus.ctrl_MULT ^ bus.ctrl_DIV;  // both high is ignored
  assign a_mag = bus.data_operandA[W-1] ? (~bus.data_operandA + 1'b1) : bus.data_operandA;
  assign b_mag = bus.data_operandB[W-1] ? (~bus.data_operandB + 1'b1) : bus.data_operandB;

  // Partial product for this iteration.
  always_comb begin
    mul_term = '0;
`ifdef MULTDIV_BOOTH4_EN
    case (mplier_q[2:0])
      3'b001, 3'b010: mul_term = mcand_q;
      3'b011:         mul_term = mcand_q << 1;
      3'b100:         mul_term = ~(mcand_q << 1) + 1'b1;
      3'b101, 3'b110: mul_term = ~mcand_q + 1'b1;
      default:        mul_term = '0;
    endcase
`else
    // The multiplier's top bit carries weight -2^(W-1), so it subtracts.
    if (mplier_q[0]) mul_term = (cnt_q == MUL_LAST) ? (~mcand_q + 1'b1) : mcand_q;
`endif
  end

  assign mul_sum = prod_q + mul_term;
  // Overflow unless the upper W+1 bits are all copies of the sign.
  assign mul_ovf = (mul_sum[2*W-1:W-1] != {(W+1){mul_sum[W-1]}});

  assign div_shift = {rem_q, quo_q[W-1]};
  assign div_ge    = (div_shift >= {1'b0, dvs_q});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;

    if (start) begin
      // A start from any state restarts with fresh operands.
      state_d  = bus.ctrl_MULT ? S_MUL : S_DIV;
      cnt_d    = '0;
      prod_d   = '0;
      mcand_d  = {{W{bus.data_operandA[W-1]}}, bus.data_operandA};
`ifdef MULTDIV_BOOTH4_EN
      mplier_d = {bus.data_operandB, 1'b0};
`else
      mplier_d = bus.data_operandB;
`endif
      quo_d    = a_mag;
      rem_d    = '0;
      dvs_d    = b_mag;
      neg_d    = bus.data_operandA[W-1] ^ bus.data_operandB[W-1];
      dz_d     = (bus.data_operandB == '0);
      ovf_d    = (bus.data_operandA == {1'b1, {(W-1){1'b0}}}) && (&bus.data_operandB);
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        S_MUL: begin
          prod_d = mul_sum;
`ifdef MULTDIV_BOOTH4_EN
          mcand_d  = mcand_q << 2;
          mplier_d = {{2{mplier_q[MPW-1]}}, mplier_q[MPW-1:2]};
`else
          mcand_d  = mcand_q << 1;
          mplier_d = {mplier_q[MPW-1], mplier_q[MPW-1:1]};
`endif
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == MUL_LAST) begin
            state_d  = S_DONE;
            result_d = mul_sum[W-1:0];
            exc_d    = mul_ovf;
            rdy_d    = 1'b1;
            busy_d   = 1'b0;
          end
        end
        S_DIV: begin
          if (dz_q) begin
            state_d  = S_DONE;
            result_d = '0;
            exc_d    = 1'b1;
            rdy_d    = 1'b1;
            busy_d   = 1'b0;
          end else begin
            rem_d = div_ge ? W'(div_shift - {1'b0, dvs_q}) : div_shift[W-1:0];
            quo_d = {quo_q[W-2:0], div_ge};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == DIV_LAST) state_d = S_FIX;
          end
        end
        S_FIX: begin
          state_d  = S_DONE;
          result_d = neg_q ? (~quo_q + 1'b1) : quo_q;
          exc_d    = ovf_q;
          rdy_d    = 1'b1;
          busy_d   = 1'b0;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;
  assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_multdiv_iter.sv
// -----------------------------------------------------------------------------
// tb_multdiv_iter -- directed and random stimulus for multdiv_iter (WIDTH=32),
// checked against an arithmetic reference model with an expected-value queue.
// -----------------------------------------------------------------------------
module tb_multdiv_iter;
  localparam int W = 32;
`ifdef MULTDIV_BOOTH4_EN
  localparam int MUL_LAT = W / 2;
`else
  localparam int MUL_LAT = W;
`endif
  localparam int DIV_LAT = W + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;
  int         checks = 0;
  int         errors = 0;

  logic [W-1:0] exp_q[$];
  logic         exc_q[$];

  multdiv_iter_if #(.WIDTH(W)) bus ();

  multdiv_iter #(.WIDTH(W)) dut (
    .clock       (clk),
    .reset       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1ms;
    errors++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic void model(input bit is_mul, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic e, output int lat);
    longint p;
    int     sa, sb;
    if (is_mul) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      r   = p[W-1:0];
      e   = (p != longint'($signed(r)));
      lat = MUL_LAT;
    end else begin
      sa  = $signed(a);
      sb  = $signed(b);
      lat = DIV_LAT;
      if (sb == 0) begin
        r = '0; e = 1'b1; lat = 1;
      end else if (a == 32'h8000_0000 && sb == -1) begin
        r = 32'h8000_0000; e = 1'b1;
      end else begin
        r = sa / sb; e = 1'b0;
      end
    end
  endfunction

  // ---------------- check ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Returns at #1 after the start edge T0.
  task automatic drive_start(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clk);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;  // operands must only matter on the start edge
    bus.data_operandB = $urandom;
  endtask

  task automatic wait_result(input string tag, input int lat);
    int           got = 0;
    logic [W-1:0] er;
    logic         ee;
    check({tag, ":busy_start"}, W'(bus.busy), W'(1));
    for (int k = 1; k <= lat + 40 && got == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.data_resultRDY) got = k;
    end
    er = exp_q.pop_front();
    ee = exc_q.pop_front();
    check({tag, ":latency"}, W'(got), W'(lat));
    check({tag, ":result"}, bus.data_result, er);
    check({tag, ":exception"}, W'(bus.data_exception), W'(ee));
    check({tag, ":busy_rdy"}, W'(bus.busy), W'(0));
    @(posedge clk);
    #1;
    check({tag, ":rdy_pulse"}, W'(bus.data_resultRDY), W'(0));
    check({tag, ":hold"}, bus.data_result, er);
  endtask

  task automatic run_op(input string tag, input bit is_mul, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         e;
    int           lat;
    model(is_mul, a, b, r, e, lat);
    exp_q.push_back(r);
    exc_q.push_back(e);
    drive_start(is_mul, !is_mul, a, b);
    wait_result(tag, lat);
  endtask

  // Watches n cycles: no RDY, no busy, no state movement.
  task automatic watch_quiet(input string tag, input int n, input logic [2:0] st0);
    int rdy_n = 0, busy_n = 0, st_n = 0;
    for (int k = 0; k < n; k++) begin
      if (bus.data_resultRDY) rdy_n++;
      if (bus.busy) busy_n++;
      if (dbg_state !== st0) st_n++;
      @(posedge clk);
      #1;
    end
    check({tag, ":rdy_count"}, W'(rdy_n), W'(0));
    check({tag, ":busy_count"}, W'(busy_n), W'(0));
    check({tag, ":state_moves"}, W'(st_n), W'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]   st0;
    logic [W-1:0] r;
    logic         e;
    int           lat;
    logic [W-1:0] a, b;
    bit           is_mul;

    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    rst               = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset:result", bus.data_result, '0);
    check("reset:exception", W'(bus.data_exception), W'(0));
    check("reset:rdy", W'(bus.data_resultRDY), W'(0));
    check("reset:busy", W'(bus.busy), W'(0));
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op("mul_7x-3", 1'b1, 32'd7, 32'hFFFF_FFFD);

    // Reset on edge T0+10 of a multiply
    drive_start(1'b1, 1'b0, 32'h0000_1234, 32'h0000_5678);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst:result", bus.data_result, '0);
    check("midrst:exception", W'(bus.data_exception), W'(0));
    check("midrst:rdy", W'(bus.data_resultRDY), W'(0));
    check("midrst:busy", W'(bus.busy), W'(0));
    st0 = dbg_state;
    @(negedge clk);
    rst = 1'b0;
    watch_quiet("midrst_quiet", 40, st0);
    run_op("mul_3x4", 1'b1, 32'd3, 32'd4);

    run_op("mul_ovf", 1'b1, 32'h0001_0000, 32'h0001_0000);
    run_op("mul_min_x_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mul_neg_neg", 1'b1, 32'hFFFF_8000, 32'hFFFF_0001);
    run_op("div_-7/2", 1'b0, 32'hFFFF_FFF9, 32'd2);
    run_op("div_5/0", 1'b0, 32'd5, 32'd0);
    run_op("div_min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_7/-7", 1'b0, 32'd7, 32'hFFFF_FFF9);
    run_op("div_3/5", 1'b0, 32'd3, 32'd5);

    // Both start pulses together: ignored
    st0 = dbg_state;
    drive_start(1'b1, 1'b1, 32'd9, 32'd9);
    watch_quiet("both_high", 40, st0);

    // DIV start on edge T0+5 of a multiply: only the divide reports
    drive_start(1'b1, 1'b0, 32'd100, 32'd200);
    repeat (4) @(posedge clk);
    run_op("abort_div", 1'b0, 32'd1000, 32'hFFFF_FFF3);
    st0 = dbg_state;
    watch_quiet("abort_quiet", 40, st0);

    // Random operations
    for (int i = 0; i < 24; i++) begin
      is_mul = 1'($urandom_range(0, 1));
      a      = $urandom;
      if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 300)) - W'(150);
      case ($urandom_range(0, 4))
        0:       b = W'($urandom_range(0, 15));
        1:       b = W'(0) - W'($urandom_range(1, 15));
        2:       b = W'($urandom_range(0, 65535));
        default: b = $urandom;
      endcase
      model(is_mul, a, b, r, e, lat);
      exp_q.push_back(r);
      exc_q.push_back(e);
      drive_start(is_mul, !is_mul, a, b);
      wait_result($sformatf("rand%0d_%s", i, is_mul ? "mul" : "div"), lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
